ram_port_arbiter: RTL and testbench

- Sits between ram_interface and ram in riscv_soc.
- Merges the core's RAM port with the JTAG debug memory-write stream (mem_we_o/mem_addr_o/mem_wdata_o from jtag_top) so debug downloads reach RAM.
- JTAG writes are buffered in a small FIFO and drained into idle RAM cycles.
- A starvation counter and the halt request bound how long JTAG writes can wait.

---
 rtl/ram_port_arbiter.sv | 119 +++++++++++
 tb/tb_ram_port_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - merges the core RAM port with the buffered JTAG debug write stream
//
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   halt_i                    core halted; queued JTAG writes take priority
//   c_wen/c_ren/c_addr/c_wdata core request (held by the core while c_busy)
//   c_rdata, c_busy           read data pass-through, request-not-granted flag
//   j_wen/j_addr/j_wdata      single-cycle JTAG write strobe, no backpressure
//   ram_wen/ram_ren/ram_addr/ram_wdata/ram_rdata   RAM side
//   j_pending, j_level, j_ovf FIFO non-empty, occupancy, sticky drop flag

module ram_port_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       halt_i,
  input  logic [3:0]                 c_wen,
  input  logic                       c_ren,
  input  logic [AW-1:0]              c_addr,
  input  logic [DW-1:0]              c_wdata,
  output logic [DW-1:0]              c_rdata,
  output logic                       c_busy,
  input  logic                       j_wen,
  input  logic [AW-1:0]              j_addr,
  input  logic [DW-1:0]              j_wdata,
  output logic [3:0]                 ram_wen,
  output logic                       ram_ren,
  output logic [AW-1:0]              ram_addr,
  output logic [DW-1:0]              ram_wdata,
  input  logic [DW-1:0]              ram_rdata,
  output logic                       j_pending,
  output logic [$clog2(DEPTH):0]     j_level,
  output logic                       j_ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [AW-1:0] q_addr [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [LW-1:0] level;
  logic [SW-1:0] starve_cnt;

  logic core_req;
  logic force_j;
  logic core_win;
  logic grant_core;
  logic grant_j;
  logic push;
  logic pop;

  assign j_level   = level;
  assign j_pending = (level != '0);
  assign c_rdata   = ram_rdata;

  always_comb begin
    core_req = (|c_wen) | c_ren;
    force_j  = j_pending & (halt_i | (starve_cnt == SW'(STARVE_MAX)));
    core_win = core_req & ~force_j;
    // Reset suppresses every grant so no RAM strobe escapes while rst is high.
    grant_core = core_win & ~rst;
    grant_j    = j_pending & ~core_win & ~rst;
    pop        = grant_j;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    push       = j_wen & ((level < LW'(DEPTH)) | pop);
    c_busy     = core_req & ~grant_core & ~rst;
  end

  always_comb begin
    ram_wen   = 4'h0;
    ram_ren   = 1'b0;
    ram_addr  = c_addr;
    ram_wdata = c_wdata;
    if (grant_core) begin
      ram_wen = c_wen;
      ram_ren = c_ren;
    end else if (grant_j) begin
      ram_wen   = 4'hF;
      ram_addr  = q_addr[rd_ptr];
      ram_wdata = q_data[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      starve_cnt <= '0;
      j_ovf      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
      if (j_wen & ~push) j_ovf <= 1'b1;
      // Counts core grants made while JTAG waits; saturation forces the next grant to JTAG.
      if (grant_j | ~j_pending)
        starve_cnt <= '0;
      else if (grant_core && (starve_cnt != SW'(STARVE_MAX)))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Storage is not reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= j_addr;
      q_data[wr_ptr] <= j_wdata;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - directed self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          halt_i = 1'b0;
  logic [3:0]    c_wen = 4'h0;
  logic          c_ren = 1'b0;
  logic [AW-1:0] c_addr = '0;
  logic [DW-1:0] c_wdata = '0;
  logic [DW-1:0] c_rdata;
  logic          c_busy;
  logic          j_wen = 1'b0;
  logic [AW-1:0] j_addr = '0;
  logic [DW-1:0] j_wdata = '0;
  logic [3:0]    ram_wen;
  logic          ram_ren;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          j_pending;
  logic [2:0]    j_level;
  logic          j_ovf;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [256] = '{default: '0};

  ram_port_arbiter #(.DW(DW), .AW(AW), .DEPTH(4), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst), .halt_i(halt_i),
    .c_wen(c_wen), .c_ren(c_ren), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_busy(c_busy),
    .j_wen(j_wen), .j_addr(j_addr), .j_wdata(j_wdata),
    .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .j_pending(j_pending), .j_level(j_level), .j_ovf(j_ovf)
  );

  always #5 clk = ~clk;

  // RAM model: byte-enabled write, one-cycle registered read.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_wen[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    if (ram_ren) ram_rdata <= mem[ram_addr[9:2]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_jw(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_wen"}, ram_wen, 4'hF);
    chk({tag, "_ren"}, ram_ren, 0);
    chk({tag, "_addr"}, ram_addr, a);
    chk({tag, "_wdata"}, ram_wdata, d);
  endtask

  task automatic jpush(input logic [31:0] a, input logic [31:0] d);
    j_wen = 1'b1; j_addr = a; j_wdata = d;
  endtask

  // Reads each address through the core port and compares the returned word.
  task automatic readback(input string tag, input logic [31:0] a0, input int n,
                          input logic [31:0] d0, input logic [31:0] dstep);
    @(negedge clk); c_wen = 4'h0; c_ren = 1'b1; c_addr = a0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == n) c_ren = 1'b0; else c_addr = a0 + 32'(4 * i);
      #1; chk(tag, c_rdata, d0 + dstep * 32'(i - 1));
    end
  endtask

  logic [31:0] exp6 [8] = '{32'hD0, 32'hD1, 32'hD2, 32'hD3, 32'hD4, 32'hD5, 32'hD6, 32'hD7};

  initial begin
    // 1: reset, with the core already requesting
    c_ren = 1'b1; c_wen = 4'hF;
    repeat (3) begin
      @(negedge clk); #1;
      chk("rst_wen", ram_wen, 0); chk("rst_ren", ram_ren, 0); chk("rst_busy", c_busy, 0);
    end
    @(negedge clk); rst = 1'b0; c_ren = 1'b0; c_wen = 4'h0; #1;
    chk("idle_wen", ram_wen, 0); chk("idle_busy", c_busy, 0);
    chk("idle_level", j_level, 0); chk("idle_ovf", j_ovf, 0); chk("idle_pend", j_pending, 0);

    // 2: idle core, three JTAG writes drain one cycle later each
    @(negedge clk); jpush(32'h10, 32'hA1); #1;
    chk("t2_nopend_same_cycle", j_pending, 0); chk("t2_wen0", ram_wen, 0);
    @(negedge clk); jpush(32'h14, 32'hA2); #1; chk_jw("t2_w0", 32'h10, 32'hA1); chk("t2_lvl", j_level, 1);
    @(negedge clk); jpush(32'h18, 32'hA3); #1; chk_jw("t2_w1", 32'h14, 32'hA2); chk("t2_lvl", j_level, 1);
    @(negedge clk); j_wen = 1'b0; #1; chk_jw("t2_w2", 32'h18, 32'hA3); chk("t2_lvl", j_level, 1);
    @(negedge clk); #1; chk("t2_empty", j_level, 0); chk("t2_wen_off", ram_wen, 0);
    readback("t2_rd", 32'h10, 3, 32'hA1, 32'h1);

    // 3: starvation bound under a continuous core read stream
    @(negedge clk); c_ren = 1'b1; c_addr = 32'h30; jpush(32'h20, 32'hDEAD); #1;
    chk("t3_busy0", c_busy, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); j_wen = 1'b0; #1;
      chk("t3_core_busy", c_busy, 0); chk("t3_core_ren", ram_ren, 1); chk("t3_pend", j_pending, 1);
    end
    @(negedge clk); #1; chk("t3_forced_busy", c_busy, 1); chk_jw("t3_forced", 32'h20, 32'hDEAD);
    @(negedge clk); #1; chk("t3_resume_busy", c_busy, 0); chk("t3_resume_ren", ram_ren, 1);
    chk("t3_resume_pend", j_pending, 0);

    // 4: queue four writes, then halt gives JTAG four consecutive grants
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); jpush(32'h40 + 32'(4 * i), 32'hB0 + 32'(i)); #1;
      chk("t4_fill_busy", c_busy, 0);
    end
    @(negedge clk); j_wen = 1'b0; halt_i = 1'b1; #1; chk("t4_full", j_level, 4);
    for (int i = 0; i < 4; i++) begin
      if (i != 0) begin @(negedge clk); #1; end
      chk("t4_busy", c_busy, 1); chk_jw("t4_grant", 32'h40 + 32'(4 * i), 32'hB0 + 32'(i));
    end
    @(negedge clk); #1; chk("t4_core_back", c_busy, 0); chk("t4_ren", ram_ren, 1); chk("t4_empty", j_level, 0);
    halt_i = 1'b0;

    // 5: overflow while the core writes continuously
    c_ren = 1'b0; c_wen = 4'hF; c_addr = 32'h60; c_wdata = 32'h5555;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); jpush(32'h80 + 32'(4 * i), 32'hC0 + 32'(i)); #1;
      chk("t5_core_wen", ram_wen, 4'hF);
      if (i == 4) chk("t5_ovf_before_drop", j_ovf, 0);
    end
    @(negedge clk); j_wen = 1'b0; c_wen = 4'h0; #1;
    chk("t5_ovf", j_ovf, 1); chk("t5_level", j_level, 4); chk_jw("t5_d0", 32'h80, 32'hC0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk); #1; chk_jw("t5_drain", 32'h80 + 32'(4 * i), 32'hC0 + 32'(i));
    end
    @(negedge clk); #1; chk("t5_empty", j_level, 0); chk("t5_ovf_sticky", j_ovf, 1); chk("t5_wen0", ram_wen, 0);
    readback("t5_rd", 32'h8C, 1, 32'hC3, 32'h0);
    readback("t5_dropped", 32'h90, 2, 32'h0, 32'h0);
    readback("t5_core_wr", 32'h60, 1, 32'h5555, 32'h0);

    // reset mid-operation discards queued writes and clears j_ovf
    @(negedge clk); c_ren = 1'b1; c_addr = 32'h30; jpush(32'hC0, 32'hE0);
    @(negedge clk); jpush(32'hC4, 32'hE1);
    @(negedge clk); j_wen = 1'b0; rst = 1'b1; #1;
    chk("mrst_wen", ram_wen, 0); chk("mrst_ren", ram_ren, 0); chk("mrst_busy", c_busy, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("mrst_level", j_level, 0); chk("mrst_pend", j_pending, 0); chk("mrst_ovf", j_ovf, 0);

    // 6: full FIFO with push during forced pop, wrap across 2*DEPTH writes
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); jpush(32'hA0 + 32'(4 * i), exp6[i]); #1;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 4) begin
        halt_i = 1'b1; jpush(32'hB0 + 32'(4 * i), exp6[i + 4]);
      end else j_wen = 1'b0;
      #1;
      chk_jw("t6_grant", (i < 4) ? 32'hA0 + 32'(4 * i) : 32'hB0 + 32'(4 * (i - 4)), exp6[i]);
      chk("t6_level", j_level, (i < 4) ? 4 : 8 - i);
    end
    @(negedge clk); halt_i = 1'b0; c_ren = 1'b0; #1;
    chk("t6_ovf", j_ovf, 0); chk("t6_empty", j_level, 0);
    readback("t6_rd_a", 32'hA0, 4, 32'hD0, 32'h1);
    readback("t6_rd_b", 32'hB0, 4, 32'hD4, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end
endmodule
